// File: rtl/muxbus_pkg.sv
// Shared types and constants for the multiplexed-bus SRAM controller.
package muxbus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        HOLD  = 3'd2,
        ACC   = 3'd3,
        RECOV = 3'd4
    } state_e;

    localparam int WS_CNT_W = 32'sd4;

    // SRAM strobes (ce_n, oe_n, we_n) are all active low
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    function automatic int bank_w(input int num_banks);
        return (num_banks > 32'sd1) ? $clog2(num_banks) : 32'sd0;
    endfunction

endpackage

// File: rtl/muxbus_bank_dec.sv
// Registered bank decoder: bank index plus enable -> one-hot-low chip enables.
module muxbus_bank_dec
    import muxbus_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int IDX_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     bank_idx,
    input  logic                 en,
    output logic [NUM_BANKS-1:0] ce_n
);

    logic [NUM_BANKS-1:0] ce_n_s;
    logic [NUM_BANKS-1:0] ce_n_r;

    // decode the selected bank into a single low chip enable
    always_comb begin
        ce_n_s = {NUM_BANKS{STROBE_OFF}};
        if (en) begin
            for (int b = 32'sd0; b < NUM_BANKS; b++) begin
                if (bank_idx == IDX_W'(b)) begin
                    ce_n_s[b] = STROBE_ON;
                end else begin
                    ce_n_s[b] = STROBE_OFF;
                end
            end
        end else begin
            ce_n_s = {NUM_BANKS{STROBE_OFF}};
        end
    end

    // register the enables so the pins only change on clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_n_r <= {NUM_BANKS{STROBE_OFF}};
        end else begin
            ce_n_r <= ce_n_s;
        end
    end

    assign ce_n = ce_n_r;

endmodule

// File: rtl/muxbus_sram_ctrl.sv
// Controller for banked async SRAMs behind an address latch on a muxed A/D bus.
// Optional MUXBUS_STATS_EN adds saturating read/write access counters.
module muxbus_sram_ctrl
    import muxbus_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int ADDR_W      = 15,
    parameter  int NUM_BANKS   = 2,
    parameter  int WAIT_STATES = 1,
    localparam int BANK_W      = bank_w(NUM_BANKS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W+BANK_W-1:0] req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     resp_valid,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic [DATA_W-1:0]        bus_ad_o,
    output logic                     bus_ad_oe,
    input  logic [DATA_W-1:0]        bus_ad_i,
    output logic [ADDR_W-DATA_W-1:0] bus_ahi,
    output logic                     ale,
    output logic [NUM_BANKS-1:0]     ce_n,
    output logic                     oe_n,
    output logic                     we_n
`ifdef MUXBUS_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [15:0]              stat_rd_cnt,
    output logic [15:0]              stat_wr_cnt
`endif
);

    localparam int IDX_W = (BANK_W > 32'sd0) ? BANK_W : 32'sd1;
    localparam int AHI_W = ADDR_W - DATA_W;

    state_e                state_r, state_s;
    logic [WS_CNT_W-1:0]   ws_cnt_r, ws_cnt_s;
    logic                  accept_s;
    logic                  busy_s;
    logic [IDX_W-1:0]      req_bank_s;

    logic                  we_r;
    logic [ADDR_W-1:0]     addr_r;
    logic [IDX_W-1:0]      bank_r;
    logic [DATA_W-1:0]     wdata_r;

    logic                  req_ready_r;
    logic                  resp_valid_r, resp_valid_s;
    logic [DATA_W-1:0]     resp_rdata_r, resp_rdata_s;
    logic [DATA_W-1:0]     bus_ad_o_r, bus_ad_o_s;
    logic                  bus_ad_oe_r, bus_ad_oe_s;
    logic [AHI_W-1:0]      bus_ahi_r, bus_ahi_s;
    logic                  ale_r, ale_s;
    logic                  oe_n_r, oe_n_s;
    logic                  we_n_r, we_n_s;

    assign accept_s = req_valid && req_ready_r;
    assign busy_s   = (state_r != IDLE);

    generate
        if (BANK_W > 0) begin : g_bank
            assign req_bank_s = req_addr[ADDR_W+BANK_W-1:ADDR_W];
        end else begin : g_single
            assign req_bank_s = {IDX_W{1'b0}};
        end
    endgenerate

    // next-state logic; ACC lasts WAIT_STATES+1 cycles via ws_cnt
    always_comb begin
        state_s  = state_r;
        ws_cnt_s = ws_cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: state_s = HOLD;
            HOLD: begin
                state_s  = ACC;
                ws_cnt_s = {WS_CNT_W{1'b0}};
            end
            ACC: begin
                if (ws_cnt_r == WS_CNT_W'(WAIT_STATES)) begin
                    state_s = RECOV;
                end else begin
                    state_s  = ACC;
                    ws_cnt_s = ws_cnt_r + 4'd1;
                end
            end
            RECOV:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // pin values for the cycle following the current state (all pins registered)
    always_comb begin
        bus_ad_o_s   = bus_ad_o_r;
        bus_ad_oe_s  = 1'b0;
        bus_ahi_s    = bus_ahi_r;
        ale_s        = 1'b0;
        oe_n_s       = STROBE_OFF;
        we_n_s       = STROBE_OFF;
        resp_valid_s = 1'b0;
        resp_rdata_s = resp_rdata_r;
        case (state_r)
            IDLE: bus_ad_oe_s = 1'b0;
            ADDR: begin
                ale_s       = 1'b1;
                bus_ad_oe_s = 1'b1;
                bus_ad_o_s  = addr_r[DATA_W-1:0];
                bus_ahi_s   = addr_r[ADDR_W-1:DATA_W];
            end
            HOLD: begin
                bus_ad_oe_s = 1'b1;
                bus_ad_o_s  = addr_r[DATA_W-1:0];
            end
            ACC: begin
                if (we_r) begin
                    bus_ad_oe_s = 1'b1;
                    bus_ad_o_s  = wdata_r;
                    we_n_s      = STROBE_ON;
                end else begin
                    oe_n_s      = STROBE_ON;
                end
            end
            RECOV: begin
                // this edge closes the last oe_n-low cycle, so read data is sampled here
                if (we_r) begin
                    bus_ad_oe_s = 1'b1;
                    bus_ad_o_s  = wdata_r;
                end else begin
                    resp_valid_s = 1'b1;
                    resp_rdata_s = bus_ad_i;
                end
            end
            default: bus_ad_oe_s = 1'b0;
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            ws_cnt_r <= {WS_CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            ws_cnt_r <= ws_cnt_s;
        end
    end

    // capture request fields at accept so the requester may change them afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            bank_r  <= {IDX_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            we_r    <= req_we;
            addr_r  <= req_addr[ADDR_W-1:0];
            bank_r  <= req_bank_s;
            wdata_r <= req_wdata;
        end
    end

    // output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {DATA_W{1'b0}};
            bus_ad_o_r   <= {DATA_W{1'b0}};
            bus_ad_oe_r  <= 1'b0;
            bus_ahi_r    <= {AHI_W{1'b0}};
            ale_r        <= 1'b0;
            oe_n_r       <= STROBE_OFF;
            we_n_r       <= STROBE_OFF;
        end else begin
            req_ready_r  <= (state_s == IDLE);
            resp_valid_r <= resp_valid_s;
            resp_rdata_r <= resp_rdata_s;
            bus_ad_o_r   <= bus_ad_o_s;
            bus_ad_oe_r  <= bus_ad_oe_s;
            bus_ahi_r    <= bus_ahi_s;
            ale_r        <= ale_s;
            oe_n_r       <= oe_n_s;
            we_n_r       <= we_n_s;
        end
    end

    muxbus_bank_dec #(
        .NUM_BANKS (NUM_BANKS),
        .IDX_W     (IDX_W)
    ) u_bank_dec (
        .clk      (clk),
        .rst_n    (rst_n),
        .bank_idx (bank_r),
        .en       (busy_s),
        .ce_n     (ce_n)
    );

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign bus_ad_o   = bus_ad_o_r;
    assign bus_ad_oe  = bus_ad_oe_r;
    assign bus_ahi    = bus_ahi_r;
    assign ale        = ale_r;
    assign oe_n       = oe_n_r;
    assign we_n       = we_n_r;

`ifdef MUXBUS_STATS_EN
    logic [15:0] stat_rd_r;
    logic [15:0] stat_wr_r;

    // saturating access counters; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_r <= 16'h0000;
            stat_wr_r <= 16'h0000;
        end else if (stat_clr) begin
            stat_rd_r <= 16'h0000;
            stat_wr_r <= 16'h0000;
        end else if (state_r == RECOV) begin
            if (we_r && (stat_wr_r != 16'hFFFF)) begin
                stat_wr_r <= stat_wr_r + 16'h0001;
            end else if (!we_r && (stat_rd_r != 16'hFFFF)) begin
                stat_rd_r <= stat_rd_r + 16'h0001;
            end
        end
    end

    assign stat_rd_cnt = stat_rd_r;
    assign stat_wr_cnt = stat_wr_r;
`endif

endmodule

// File: tb/tb_muxbus_sram_ctrl.sv
// Directed bench for muxbus_sram_ctrl with a behavioural address latch and two SRAM banks.
module tb_muxbus_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic [7:0]  bus_ad_o;
    logic        bus_ad_oe;
    logic [7:0]  bus_ad_i;
    logic [6:0]  bus_ahi;
    logic        ale;
    logic [1:0]  ce_n;
    logic        oe_n;
    logic        we_n;
`ifdef MUXBUS_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    muxbus_sram_ctrl #(
        .DATA_W(8), .ADDR_W(15), .NUM_BANKS(2), .WAIT_STATES(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .bus_ad_o(bus_ad_o), .bus_ad_oe(bus_ad_oe), .bus_ad_i(bus_ad_i),
        .bus_ahi(bus_ahi), .ale(ale), .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n)
`ifdef MUXBUS_STATS_EN
        , .stat_clr(stat_clr), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
    );

    // board model: transparent latch on ALE, two async SRAMs sharing the bus
    logic [7:0]  mem [0:1][0:32767];
    logic [7:0]  latch_q;
    logic [14:0] sram_addr;
    logic        rd_drive;
    logic [7:0]  rd_data;

    always_latch begin
        if (ale) latch_q <= bus_ad_o;
    end

    assign sram_addr = {bus_ahi, latch_q};
    assign rd_drive  = (oe_n == 1'b0) && (ce_n != 2'b11);
    assign rd_data   = (ce_n[0] == 1'b0) ? mem[0][sram_addr] : mem[1][sram_addr];
    assign bus_ad_i  = bus_ad_oe ? bus_ad_o : (rd_drive ? rd_data : 8'hzz);

    always @(negedge clk) begin
        if (we_n == 1'b0) begin
            if (ce_n[0] == 1'b0) mem[0][sram_addr] <= bus_ad_i;
            if (ce_n[1] == 1'b0) mem[1][sram_addr] <= bus_ad_i;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // present a request once req_ready is seen; returns just after the accept edge
    task automatic issue(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, output logic got, output logic [7:0] data);
        int n = 0;
        issue(1'b0, addr, 8'h00);
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        got  = (resp_valid === 1'b1);
        data = resp_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        rst_n = 1'b0;
        #12;
        obs = {req_ready, resp_valid, resp_rdata, bus_ad_o, bus_ad_oe, bus_ahi, ale, ce_n, oe_n, we_n};
        tests_run++;
        if (obs !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 7'h00, 1'b0, 2'b11, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_values: got %h, required %h", obs,
                     {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 7'h00, 1'b0, 2'b11, 1'b1, 1'b1});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: req_ready=%b resp_valid=%b, required 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_write();
        int ale_cnt = 0, we_cnt = 0, we_bad = 0;
        issue(1'b1, {1'b1, 15'h0123}, 8'h5A);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ale === 1'b1) ale_cnt++;
            if (we_n === 1'b0) begin
                we_cnt++;
                if (bus_ad_o !== 8'h5A || bus_ad_oe !== 1'b1) we_bad++;
            end
            if (k == 1) begin
                tests_run++;
                if ({ale, bus_ad_oe, bus_ad_o, bus_ahi, ce_n} !== {1'b1, 1'b1, 8'h23, 7'h01, 2'b01}) begin
                    tests_failed++;
                    $display("FAIL write_addr_phase: ale=%b oe=%b ad=%h ahi=%h ce_n=%b, required 1 1 23 01 01",
                             ale, bus_ad_oe, bus_ad_o, bus_ahi, ce_n);
                end
            end
            if (k == 2) begin
                tests_run++;
                if ({ale, bus_ad_oe, bus_ad_o} !== {1'b0, 1'b1, 8'h23}) begin
                    tests_failed++;
                    $display("FAIL write_hold_phase: ale=%b oe=%b ad=%h, required 0 1 23", ale, bus_ad_oe, bus_ad_o);
                end
            end
            if (k == 5) begin
                tests_run++;
                if ({we_n, bus_ad_oe, bus_ad_o, ce_n} !== {1'b1, 1'b1, 8'h5A, 2'b01}) begin
                    tests_failed++;
                    $display("FAIL write_recov: we_n=%b oe=%b ad=%h ce_n=%b, required 1 1 5a 01",
                             we_n, bus_ad_oe, bus_ad_o, ce_n);
                end
            end
            if (k == 6) begin
                tests_run++;
                if ({bus_ad_oe, ce_n, req_ready} !== {1'b0, 2'b11, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL write_release: oe=%b ce_n=%b ready=%b, required 0 11 1", bus_ad_oe, ce_n, req_ready);
                end
            end
        end
        tests_run++;
        if (ale_cnt != 1 || we_cnt != 2 || we_bad != 0) begin
            tests_failed++;
            $display("FAIL write_strobes: ale_cycles=%0d we_cycles=%0d we_bad=%0d, required 1 2 0", ale_cnt, we_cnt, we_bad);
        end
        tests_run++;
        if (mem[1][15'h0123] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL write_mem: bank1[0123]=%h, required 5a", mem[1][15'h0123]);
        end
    endtask

    task automatic test_read();
        int resp_k = -1, pulses = 0, oe_cnt = 0, viol = 0;
        logic [7:0] rd = 8'h00;
        issue(1'b0, {1'b1, 15'h0123}, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (oe_n === 1'b0) begin
                oe_cnt++;
                if (bus_ad_oe !== 1'b0) viol++;
            end
            if (resp_valid === 1'b1) begin
                pulses++;
                resp_k = k;
                rd = resp_rdata;
            end
        end
        tests_run++;
        if (resp_k != 5 || pulses != 1) begin
            tests_failed++;
            $display("FAIL read_latency: resp at cycle %0d (%0d pulses), required cycle 5 (1 pulse)", resp_k, pulses);
        end
        tests_run++;
        if (rd !== 8'h5A) begin
            tests_failed++;
            $display("FAIL read_data: got %h, required 5a", rd);
        end
        tests_run++;
        if (oe_cnt != 2 || viol != 0) begin
            tests_failed++;
            $display("FAIL read_turnaround: oe_cycles=%0d oe_with_drive=%0d, required 2 0", oe_cnt, viol);
        end
        tests_run++;
        if (resp_rdata !== 8'h5A) begin
            tests_failed++;
            $display("FAIL read_hold: resp_rdata=%h after pulse, required 5a", resp_rdata);
        end
    endtask

    task automatic test_bank_isolation();
        logic got;
        logic [7:0] d;
        issue(1'b1, {1'b0, 15'h0000}, 8'h07);
        issue(1'b1, {1'b1, 15'h0000}, 8'h00);
        do_read({1'b0, 15'h0000}, got, d);
        tests_run++;
        if (got !== 1'b1 || d !== 8'h07) begin
            tests_failed++;
            $display("FAIL bank0_read: valid=%b data=%h, required 1 07", got, d);
        end
        do_read({1'b1, 15'h0000}, got, d);
        tests_run++;
        if (got !== 1'b1 || d !== 8'h00) begin
            tests_failed++;
            $display("FAIL bank1_read: valid=%b data=%h, required 1 00", got, d);
        end
    endtask

    task automatic test_back_to_back();
        int acc_cyc [8];
        int cyc = 0, idx = 0, bad_gap = 0, bad_mem = 0;
        logic rdy;
        logic [14:0] a;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1;
        req_addr = {1'b0, 15'h0100}; req_wdata = 8'hA0;
        while (idx < 8 && cyc < 200) begin
            rdy = req_ready;
            @(posedge clk);
            cyc++;
            if (rdy === 1'b1) begin
                acc_cyc[idx] = cyc;
                idx++;
                #1;
                if (idx < 8) begin
                    a = 15'h0100 + 15'(idx);
                    req_addr  = {idx[0], a};
                    req_wdata = 8'hA0 + 8'(idx);
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++;
        if (idx != 8) begin
            tests_failed++;
            $display("FAIL b2b_accepts: %0d accepted, required 8", idx);
        end
        for (int i = 1; i < 8; i++) begin
            if (i < idx && acc_cyc[i] - acc_cyc[i-1] != 6) bad_gap++;
        end
        tests_run++;
        if (bad_gap != 0) begin
            tests_failed++;
            $display("FAIL b2b_spacing: %0d gaps not equal to 6 cycles, required 0", bad_gap);
        end
        for (int i = 0; i < 8; i++) begin
            a = 15'h0100 + 15'(i);
            if (mem[i % 2][a] !== 8'hA0 + 8'(i)) bad_mem++;
        end
        tests_run++;
        if (bad_mem != 0) begin
            tests_failed++;
            $display("FAIL b2b_mem: %0d locations wrong, required 0", bad_mem);
        end
    endtask

    task automatic test_abort();
        int n = 0, pulses = 0;
        logic got;
        logic [7:0] d;
        issue(1'b1, {1'b0, 15'h0042}, 8'hC3);
        while (we_n !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (we_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_reach_acc: we_n=%b, required 0", we_n);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({we_n, ce_n, bus_ad_oe, ale, req_ready} !== {1'b1, 2'b11, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL abort_release: we_n=%b ce_n=%b oe=%b ale=%b ready=%b, required 1 11 0 0 1",
                     we_n, ce_n, bus_ad_oe, ale, req_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL abort_no_resp: %0d resp_valid cycles, required 0", pulses);
        end
        issue(1'b1, {1'b1, 15'h7FFF}, 8'h3C);
        do_read({1'b1, 15'h7FFF}, got, d);
        tests_run++;
        if (got !== 1'b1 || d !== 8'h3C) begin
            tests_failed++;
            $display("FAIL abort_recovery: valid=%b data=%h, required 1 3c", got, d);
        end
    endtask

`ifdef MUXBUS_STATS_EN
    task automatic test_stats();
        logic got;
        logic [7:0] d;
        @(negedge clk); stat_clr = 1'b1;
        @(negedge clk); stat_clr = 1'b0;
        issue(1'b1, {1'b0, 15'h0010}, 8'h11);
        issue(1'b1, {1'b0, 15'h0011}, 8'h22);
        issue(1'b1, {1'b1, 15'h0012}, 8'h33);
        do_read({1'b0, 15'h0010}, got, d);
        do_read({1'b1, 15'h0012}, got, d);
        repeat (3) @(negedge clk);
        tests_run++;
        if (stat_wr_cnt !== 16'd3 || stat_rd_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL stats_count: wr=%0d rd=%0d, required 3 2", stat_wr_cnt, stat_rd_cnt);
        end
        stat_clr = 1'b1;
        @(negedge clk); stat_clr = 1'b0;
        tests_run++;
        if (stat_wr_cnt !== 16'd0 || stat_rd_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL stats_clear: wr=%0d rd=%0d, required 0 0", stat_wr_cnt, stat_rd_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bank_isolation();
        test_back_to_back();
        test_abort();
`ifdef MUXBUS_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
